// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder/subtractor that reuses one 4-bit
// ripple-carry slice, processing one nibble per clock from LSB to MSB.
// Subtraction is A + ~B + 1, so sum[WIDTH] is the no-borrow flag.

// 4-bit ripple-carry slice; bit 4 of sum is the carry-out.
module rca4b (
    input  logic [3:0] inA,
    input  logic [3:0] inB,
    input  logic       cin,
    output logic [4:0] sum
);

    assign sum = {1'b0, inA} + {1'b0, inB} + {4'b0000, cin};

endmodule

// State table:
//   IDLE | waiting for start; operands are latched when start is seen
//   RUN  | one nibble per cycle through the slice, idx selects the nibble
//   DONE | result already on sum/ovf; done pulses for this single cycle
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [4:0]       slice_sum;
    logic             last;

    assign nib_a = opA[{idx, 2'b00} +: 4];
    assign nib_b = opB[{idx, 2'b00} +: 4];
    assign last  = (idx == IDX_W'(N - 1));

    rca4b u_slice (
        .inA (nib_a),
        .inB (nib_b),
        .cin (carry),
        .sum (slice_sum)
    );

    // Accumulator with the current slice nibble merged in; on the last
    // nibble this is the complete low WIDTH bits of the result.
    always_comb begin
        acc_next = acc;
        acc_next[{idx, 2'b00} +: 4] = slice_sum[3:0];
    end

    // Sequencer: operand capture, nibble stepping, result publish, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            ovf   <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            opA   <= '0;
            opB   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opA   <= inA;
                        opB   <= op_sub ? ~inB : inB;
                        carry <= op_sub ? 1'b1 : cin;
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= slice_sum[4];
                    if (last) begin
                        // Partial results never reach sum; publish only here.
                        sum   <= {slice_sum[4], acc_next};
                        ovf   <= (opA[WIDTH-1] == opB[WIDTH-1]) &&
                                 (slice_sum[3] != opA[WIDTH-1]);
                        idx   <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16): directed and random operations
// against an integer arithmetic model, plus protocol scenarios.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;
    localparam int LAT   = N + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   sum;
    logic             ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .inA    (inA),
        .inB    (inB),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, result modulo 2^(WIDTH+1).
    function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic sub, input logic c);
        longint r;
        if (sub) r = longint'(a) - longint'(b) + (longint'(1) << WIDTH);
        else     r = longint'(a) + longint'(b) + longint'(c);
        return r[WIDTH:0];
    endfunction

    function automatic logic model_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic sub, input logic c);
        longint sa, sb, r;
        sa = a[WIDTH-1] ? longint'(a) - (longint'(1) << WIDTH) : longint'(a);
        sb = b[WIDTH-1] ? longint'(b) - (longint'(1) << WIDTH) : longint'(b);
        r  = sub ? sa - sb : sa + sb + longint'(c);
        return (r > (longint'(1) << (WIDTH - 1)) - 1) || (r < -(longint'(1) << (WIDTH - 1)));
    endfunction

    // Issue one operation and collect what the DUT shows; no checking here.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic c,
                          output logic [WIDTH:0] r_sum, output logic r_ovf, output int lat,
                          output logic busy_at_done, output logic done_after, output logic busy_after);
        int guard;
        guard = 0;
        while (busy && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        inA = a; inB = b; op_sub = sub; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        inA = $urandom; inB = $urandom; op_sub = $urandom; cin = $urandom;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r_sum = sum; r_ovf = ovf; busy_at_done = busy;
        @(posedge clk); #1;
        done_after = done; busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op_sub = 1'b0; cin = 1'b1;
        inA = 16'h1234; inB = 16'h4321;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", done); end
        tests_run++; if (sum !== '0) begin tests_failed++; $display("FAIL reset_sum got %h exp 0", sum); end
        tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_nostart got busy %b exp 0", busy); end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [7] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0007};
        logic [WIDTH-1:0] vb [7] = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h0007, 16'h0005};
        logic             vs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic             vc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [WIDTH:0]   es [7] = '{17'h05555, 17'h10000, 17'h10000, 17'h08000, 17'h10000, 17'h0FFFE, 17'h10002};
        logic             eo [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [WIDTH:0] r_sum;
        logic r_ovf, bd, da, ba;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], vs[i], vc[i], r_sum, r_ovf, lat, bd, da, ba);
            tests_run++; if (r_sum !== es[i]) begin tests_failed++; $display("FAIL dir%0d_sum got %h exp %h", i, r_sum, es[i]); end
            tests_run++; if (r_ovf !== eo[i]) begin tests_failed++; $display("FAIL dir%0d_ovf got %b exp %b", i, r_ovf, eo[i]); end
            tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, LAT); end
            tests_run++; if (bd !== 1'b1) begin tests_failed++; $display("FAIL dir%0d_busy_with_done got %b exp 1", i, bd); end
            tests_run++; if (da !== 1'b0 || ba !== 1'b0) begin
                tests_failed++; $display("FAIL dir%0d_after got done %b busy %b exp 0 0", i, da, ba);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        logic s, c, r_ovf, bd, da, ba;
        logic [WIDTH:0] r_sum;
        int lat;
        for (int i = 0; i < 60; i++) begin
            a = $urandom; b = $urandom; s = $urandom; c = $urandom;
            if (i % 10 == 0) a = {1'b0, {(WIDTH-1){1'b1}}};
            if (i % 10 == 1) b = {1'b1, {(WIDTH-1){1'b0}}};
            run_op(a, b, s, c, r_sum, r_ovf, lat, bd, da, ba);
            tests_run++; if (r_sum !== model_sum(a, b, s, c)) begin
                tests_failed++; $display("FAIL rnd%0d_sum a=%h b=%h sub=%b cin=%b got %h exp %h",
                                         i, a, b, s, c, r_sum, model_sum(a, b, s, c));
            end
            tests_run++; if (r_ovf !== model_ovf(a, b, s, c)) begin
                tests_failed++; $display("FAIL rnd%0d_ovf a=%h b=%h sub=%b cin=%b got %b exp %b",
                                         i, a, b, s, c, r_ovf, model_ovf(a, b, s, c));
            end
            tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, LAT); end
        end
    endtask

    task automatic test_start_while_busy();
        logic [WIDTH:0] r_sum, prev;
        logic r_ovf, bd, da, ba;
        int lat, ndone, done_cyc;
        logic [WIDTH:0] got_sum;
        logic got_ovf;
        run_op(16'h0A0A, 16'h1111, 1'b0, 1'b0, r_sum, r_ovf, lat, bd, da, ba);
        prev = model_sum(16'h0A0A, 16'h1111, 1'b0, 1'b0);
        inA = 16'h2468; inB = 16'h1357; op_sub = 1'b1; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; done_cyc = 0; got_sum = '0; got_ovf = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 2 || cyc == 3) begin
                start = 1'b1; inA = 16'hFFFF; inB = 16'hFFFF; op_sub = 1'b0; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (cyc == 2) begin
                tests_run++; if (sum !== prev) begin tests_failed++; $display("FAIL swb_partial_hidden got %h exp %h", sum, prev); end
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin done_cyc = cyc; got_sum = sum; got_ovf = ovf; end
            end
        end
        tests_run++; if (ndone != 1) begin tests_failed++; $display("FAIL swb_done_count got %0d exp 1", ndone); end
        tests_run++; if (done_cyc != LAT - 1) begin tests_failed++; $display("FAIL swb_done_edge got %0d exp %0d", done_cyc, LAT - 1); end
        tests_run++; if (got_sum !== model_sum(16'h2468, 16'h1357, 1'b1, 1'b0)) begin
            tests_failed++; $display("FAIL swb_sum got %h exp %h", got_sum, model_sum(16'h2468, 16'h1357, 1'b1, 1'b0));
        end
        tests_run++; if (got_ovf !== model_ovf(16'h2468, 16'h1357, 1'b1, 1'b0)) begin
            tests_failed++; $display("FAIL swb_ovf got %b exp %b", got_ovf, model_ovf(16'h2468, 16'h1357, 1'b1, 1'b0));
        end
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH:0] r_sum;
        logic r_ovf, bd, da, ba;
        int lat, ndone;
        run_op(16'h7000, 16'h1000, 1'b0, 1'b1, r_sum, r_ovf, lat, bd, da, ba);
        tests_run++; if (r_sum !== 17'h08001 || r_ovf !== 1'b1) begin
            tests_failed++; $display("FAIL rmr_pre got sum %h ovf %b exp 08001 1", r_sum, r_ovf);
        end
        inA = 16'h1111; inB = 16'h2222; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmr_busy got %b exp 0", busy); end
        tests_run++; if (sum !== '0) begin tests_failed++; $display("FAIL rmr_sum got %h exp 0", sum); end
        tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL rmr_ovf got %b exp 0", ovf); end
        ndone = (done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        tests_run++; if (ndone != 0) begin tests_failed++; $display("FAIL rmr_no_done got %0d pulses exp 0", ndone); end
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, r_sum, r_ovf, lat, bd, da, ba);
        tests_run++; if (r_sum !== 17'h03333) begin tests_failed++; $display("FAIL rmr_fresh_sum got %h exp 03333", r_sum); end
        tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL rmr_fresh_latency got %0d exp %0d", lat, LAT); end
    endtask

    task automatic test_back_to_back();
        int ndone;
        int edges [4];
        logic [WIDTH:0] sums [4];
        logic [WIDTH:0] exp_sum;
        exp_sum = model_sum(16'hC0DE, 16'h0F0F, 1'b1, 1'b0);
        inA = 16'hC0DE; inB = 16'h0F0F; op_sub = 1'b1; cin = 1'b0; start = 1'b1;
        ndone = 0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            if (done && ndone < 4) begin
                edges[ndone] = e; sums[ndone] = sum; ndone++;
            end
        end
        start = 1'b0;
        tests_run++; if (ndone != 2) begin tests_failed++; $display("FAIL b2b_count got %0d exp 2", ndone); end
        if (ndone >= 2) begin
            tests_run++; if (edges[0] != LAT) begin tests_failed++; $display("FAIL b2b_first got edge %0d exp %0d", edges[0], LAT); end
            tests_run++; if (edges[1] - edges[0] != N + 2) begin
                tests_failed++; $display("FAIL b2b_spacing got %0d exp %0d", edges[1] - edges[0], N + 2);
            end
            tests_run++; if (sums[0] !== exp_sum || sums[1] !== exp_sum) begin
                tests_failed++; $display("FAIL b2b_sum got %h %h exp %h", sums[0], sums[1], exp_sum);
            end
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; inA = '0; inB = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
